// File: rtl/rv32i_types.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 operations and FSM states.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/radix2_div.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle, MSB first.
// The first iteration happens on the load edge, so done pulses XLEN-1 cycles after start.
module radix2_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dsr);
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
    sh   = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dsr};
    if (diff[XLEN]) begin
      return {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    end else begin
      return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
    end
  endfunction

  // Iteration control and datapath next state.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = {CW{1'b0}};
    end else if (start) begin
      {rem_d, quo_d} = div_step({XLEN{1'b0}}, dividend, divisor);
      dsr_d  = divisor;
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {rem_d, quo_d} = div_step(rem_q, quo_q, dsr_q);
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(XLEN - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= {XLEN{1'b0}};
      quo_q  <= {XLEN{1'b0}};
      dsr_q  <= {XLEN{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/rv32m_muldiv.sv
// RV32M multiply/divide unit: IDLE/BUSY/DONE FSM, sign handling and shift-add multiplier.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module rv32m_muldiv #(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import rv32i_types::*;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  muldiv_funct3_t  op_q, op_d, op_s;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            signed_a_s, signed_b_s, a_neg_s, b_neg_s, neg_s;
  logic            div_zero_s, ovf_s, early_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, early_res_s, div_val_s, div_res_s;
  logic            div_start_s, div_busy_s, div_done_s;
  logic [XLEN-1:0] div_quo_s, div_rem_s;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s, fast_fin_s;
  logic [XLEN-1:0]   fast_res_s;
`else
  localparam int CW = $clog2(XLEN) + 1;
  logic [2*XLEN-1:0] prod_q, prod_d, mul_fin_s;
  logic [XLEN-1:0]   mcand_q, mcand_d, mul_res_s;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Shift-add step: add the multiplicand on the current multiplier LSB, then shift right.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] prod,
                                                 input logic [XLEN-1:0] mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : {XLEN{1'b0}})};
    return {sum, prod[XLEN-1:1]};
  endfunction
`endif

  // Operand decode: signedness, magnitudes, result sign and early completions.
  always_comb begin
    op_s       = muldiv_funct3_t'(funct3[2:0]);
    signed_a_s = (op_s == F3_MULH) || (op_s == F3_MULHSU) || (op_s == F3_DIV) || (op_s == F3_REM);
    signed_b_s = (op_s == F3_MULH) || (op_s == F3_DIV) || (op_s == F3_REM);
    a_neg_s    = signed_a_s & a[XLEN-1];
    b_neg_s    = signed_b_s & b[XLEN-1];
    a_mag_s    = a_neg_s ? (~a + XLEN'(1)) : a;
    b_mag_s    = b_neg_s ? (~b + XLEN'(1)) : b;
    // Remainder sign follows the dividend only; everything else takes sign(a)^sign(b).
    neg_s      = a_neg_s ^ (b_neg_s & (op_s != F3_REM));
    div_zero_s = (b == {XLEN{1'b0}});
    ovf_s      = ((op_s == F3_DIV) || (op_s == F3_REM)) && (a == MOST_NEG) && (b == {XLEN{1'b1}});
`ifdef MULDIV_FAST_MUL_EN
    fast_prod_s = {{XLEN{1'b0}}, a_mag_s} * {{XLEN{1'b0}}, b_mag_s};
    fast_fin_s  = neg_s ? (~fast_prod_s + (2*XLEN)'(1)) : fast_prod_s;
    fast_res_s  = (op_s == F3_MUL) ? fast_fin_s[XLEN-1:0] : fast_fin_s[2*XLEN-1:XLEN];
    early_s     = ~funct3[2] | div_zero_s | ovf_s;
`else
    early_s     = funct3[2] & (div_zero_s | ovf_s);
`endif
    case (op_s)
      F3_DIV, F3_DIVU: early_res_s = div_zero_s ? {XLEN{1'b1}} : a;
      F3_REM, F3_REMU: early_res_s = div_zero_s ? a : {XLEN{1'b0}};
`ifdef MULDIV_FAST_MUL_EN
      default:         early_res_s = fast_res_s;
`else
      default:         early_res_s = {XLEN{1'b0}};
`endif
    endcase
  end

  // Final sign correction of the iterative results.
  always_comb begin
    div_val_s = ((op_q == F3_REM) || (op_q == F3_REMU)) ? div_rem_s : div_quo_s;
    div_res_s = neg_q ? (~div_val_s + XLEN'(1)) : div_val_s;
`ifndef MULDIV_FAST_MUL_EN
    mul_fin_s = neg_q ? (~prod_q + (2*XLEN)'(1)) : prod_q;
    mul_res_s = (op_q == F3_MUL) ? mul_fin_s[XLEN-1:0] : mul_fin_s[2*XLEN-1:XLEN];
`endif
  end

  // FSM next state, operand capture and result update.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    result_d    = result_q;
    div_start_s = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op_s;
          neg_d = neg_s;
          if (early_s) begin
            state_d  = DONE;
            result_d = early_res_s;
`ifndef MULDIV_FAST_MUL_EN
          end else if (funct3[2] == 1'b0) begin
            state_d = BUSY;
            prod_d  = mul_step({{XLEN{1'b0}}, b_mag_s}, a_mag_s);
            mcand_d = a_mag_s;
            cnt_d   = {CW{1'b0}};
`endif
          end else begin
            state_d     = BUSY;
            div_start_s = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifndef MULDIV_FAST_MUL_EN
        if (op_q[2] == 1'b0) begin
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d  = DONE;
            result_d = mul_res_s;
          end else begin
            prod_d = mul_step(prod_q, mcand_q);
            cnt_d  = cnt_q + CW'(1);
          end
        end else
`endif
        if (div_done_s) begin
          state_d  = DONE;
          result_d = div_res_s;
        end else if (!div_busy_s) begin
          // Divider lost its operation without finishing: recover rather than hang.
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      result_d    = result_q;
      div_start_s = 1'b0;
    end else begin
      div_start_s = div_start_s;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= F3_MUL;
      neg_q    <= 1'b0;
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

`ifndef MULDIV_FAST_MUL_EN
  // Shift-add multiplier registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q  <= {(2*XLEN){1'b0}};
      mcand_q <= {XLEN{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  radix2_div #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (flush),
    .start     (div_start_s),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Self-checking bench for rv32m_muldiv (XLEN=32): directed corner cases plus random ops
// against an arithmetic reference model; multiply latency follows MULDIV_FAST_MUL_EN.
module tb_rv32m_muldiv;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, ready, done;
  logic [2:0]  funct3;
  logic [31:0] a, b, result;
  int          tests = 0;
  int          fails = 0;

  rv32m_muldiv #(.XLEN(32), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, ps;
    longint unsigned ux, uy, pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      3'd0: begin pu = ux * uy; return pu[31:0]; end
      3'd1: begin ps = sx * sy; return ps[63:32]; end
      3'd2: begin ps = sx * $signed(uy); return ps[63:32]; end
      3'd3: begin pu = ux * uy; return pu[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        ps = sx / sy; return ps[31:0];
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        pu = ux / uy; return pu[31:0];
      end
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        ps = sx % sy; return ps[31:0];
      end
      default: begin
        if (y == 32'd0) return x;
        pu = ux % uy; return pu[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op < 3'd4) return MUL_LAT;
    if (y == 32'd0) return 0;
    if ((op == 3'd4 || op == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
    return DIV_LAT;
  endfunction

  // Issue one op; latency = extra cycles after the accept edge until done is seen.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input int exp_lat, input bit noisy);
    int lat;
    @(negedge clk);
    check("ready_idle", ready, 1'b1);
    funct3 = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (exp_lat > 0) check("ready_low_busy", ready, 1'b0);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1)); funct3 = 3'($urandom); a = $urandom; b = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("result", result, exp_res);
    check("ready_low_done", ready, 1'b0);
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("result_hold", result, exp_res);
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    logic [31:0] prev, x, y;
    logic [2:0]  op;
    int          sel;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
    issue(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    issue(3'd7, 32'd100, 32'd0, 32'd100, 0, 1'b0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
    issue(3'd0, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, MUL_LAT, 1'b0);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
    issue(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, 1'b0);
    issue(3'd5, 32'd1000, 32'd7, 32'd142, DIV_LAT, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); x = $urandom; y = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 15));
      else y = y;
      issue(op, x, y, model(op, x, y), model_lat(op, x, y), (i % 3) == 0);
    end

    // Flush during BUSY cycle 10 of a divu.
    @(negedge clk);
    prev = result;
    funct3 = 3'd5; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", ready, 1'b1);
    check("flush_done", done, 1'b0);
    check("flush_result_kept", result, prev);
    watch_no_done("flush_no_done", 40);
    issue(3'd5, 32'd1000, 32'd7, 32'd142, DIV_LAT, 1'b0);

    // Flush and start together in IDLE: request dropped.
    @(negedge clk);
    prev = result;
    funct3 = 3'd4; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_ready", ready, 1'b1);
    watch_no_done("flush_start_no_done", 40);
    check("flush_start_result", result, prev);

    // Reset at BUSY cycle 5.
    @(negedge clk);
    funct3 = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_result", result, 32'd0);
    check("midreset_done", done, 1'b0);
    check("midreset_ready", ready, 1'b1);
    watch_no_done("midreset_no_done", 40);
    issue(3'd7, 32'd1000, 32'd7, 32'd6, DIV_LAT, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv.md
RV32M_MULDIV -- requirements
Module: rv32m_muldiv

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand and result width in bits (legal values 8 to 64, even).
REQ-002 The module SHALL have parameter OP_W, default 3, meaning funct3 width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit: request valid; sampled only when ready=1.
REQ-006 The module SHALL have port funct3, input, OP_W bits: operation (000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu).
REQ-007 The module SHALL have ports a and b, inputs, XLEN bits each: rs1 and rs2 operands.
REQ-008 The module SHALL have port flush, input, 1 bit: abort the in-flight operation.
REQ-009 The module SHALL have port ready, output, 1 bit: high when in IDLE and able to accept start.
REQ-010 The module SHALL have port done, output, 1 bit: single-cycle pulse; result is valid only while done=1.
REQ-011 The module SHALL have port result, output, XLEN bits: operation result.

Function
REQ-012 The module SHALL implement the states IDLE, BUSY and DONE.
REQ-013 On start=1 in IDLE, the module SHALL latch funct3, a and b, and go to BUSY; a cycle without start SHALL remain in IDLE.
REQ-014 BUSY SHALL last exactly XLEN cycles, then go to DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-015 A start accepted at edge N SHALL therefore give done=1 in cycle N+XLEN+1.
REQ-016 Division SHALL be radix-2 restoring, one quotient bit per cycle, MSB first.
REQ-017 Signed operands SHALL be converted to magnitudes before the iteration.
REQ-018 After the iteration, the quotient sign SHALL be sign(a) XOR sign(b), and the remainder sign SHALL follow the dividend.
REQ-019 Multiply SHALL form a 2*XLEN-bit product; mul returns the low XLEN bits; mulh, mulhsu and mulhu return the high XLEN bits with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-020 Division by zero SHALL complete early (DONE in cycle N+1, skipping BUSY): div and divu return all-ones; rem and remu return a.
REQ-021 Signed overflow (a = most negative value, b = -1, div or rem) SHALL complete early: div returns a; rem returns 0.
REQ-022 A start while ready=0 SHALL be ignored: no state change and no queuing.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge, suppress done, and leave result unchanged.
REQ-024 flush and start in the same IDLE cycle: flush SHALL win and the request is dropped.
REQ-025 ready SHALL be 1 in IDLE only; ready=0 during DONE, so back-to-back issue is no sooner than the cycle after done.
REQ-026 result SHALL hold its last value outside DONE.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, ready=1, done=0, result=0, and clear all iteration counters and registers.
REQ-028 Reset asserted mid-operation SHALL abandon the operation, with no done pulse.

Configuration
REQ-029 The design SHALL use the macro MULDIV_FAST_MUL_EN.
REQ-030 With MULDIV_FAST_MUL_EN defined, all multiply ops SHALL be a single-cycle combinational product: IDLE to DONE directly, done in cycle N+1.
REQ-031 Without MULDIV_FAST_MUL_EN, multiply SHALL be iterative shift-add over XLEN BUSY cycles, with done in cycle N+XLEN+1.
REQ-032 Division timing SHALL be identical in both builds.

Structure
REQ-033 Package rv32i_types SHALL gain typedef muldiv_funct3_t (the eight encodings above) and typedef muldiv_state_t (IDLE, BUSY, DONE).
REQ-034 The restoring divide iteration SHALL be a sub-module, radix2_div, parametrised by XLEN, with start, busy and done handshake and quotient and remainder outputs.
REQ-035 Sign handling and the FSM SHALL stay in rv32m_muldiv.

Verification (XLEN=32)
REQ-036 div with a=-7 (0xFFFFFFF9) and b=2 SHALL give result 0xFFFFFFFD (-3) in cycle N+33; rem SHALL give 0xFFFFFFFF (-1).
REQ-037 divu with a=100 and b=0 SHALL give 0xFFFFFFFF in cycle N+1; remu SHALL give 100.
REQ-038 div with a=0x80000000 and b=0xFFFFFFFF SHALL give 0x80000000 early; rem SHALL give 0.
REQ-039 mulh with a=0x80000000 and b=0x80000000 SHALL give 0x40000000; mulhu with a=0xFFFFFFFF and b=0xFFFFFFFF SHALL give 0xFFFFFFFE; latency SHALL be 1 cycle with the macro and 33 cycles without.
REQ-040 divu with a=1000 and b=7, with flush=1 at BUSY cycle 10, SHALL give no done, ready=1 on the next cycle, and a following divu of 1000 by 7 SHALL return 142.
REQ-041 A start pulsed every cycle during BUSY SHALL be ignored, with exactly one done per accepted start; rst_n=0 at BUSY cycle 5 SHALL give result=0 and no done.
